mul_sequencer: RTL
==================

// Module: mul_sequencer
// PURPOSE
//  Iterative shift-add multiplier controller for MUL (alu_op = 2'b11) in the EX stage.
//  Latches operands, sequences WIDTH add/shift steps, stalls the pipeline while busy,
//  and returns the low WIDTH bits of the product (RISC-V MUL semantics).
//  Replaces a single-cycle combinational multiply; sits beside the ALU, feeding the EX result mux.
// PARAMETERS
//  WIDTH    32  operand/result width in bits (>= 4)
//  CNT_W    $clog2(WIDTH)  step-counter width (derived, not overridden)
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  rst        in   1      synchronous reset, active-high
//  start      in   1      EX holds a MUL (decoded alu_op == MUL_OPCODE)
//  flush      in   1      EX squashed (branch/jump taken); abort in-flight multiply
//  operand_a  in   WIDTH  multiplicand (rs1 value)
//  operand_b  in   WIDTH  multiplier (rs2 value)
//  stall      out  1      freeze PC/IF/ID/ID-EX registers
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle pulse: result valid, pipeline advances this cycle
//  result     out  WIDTH  low WIDTH bits of operand_a*operand_b, registered
// BEHAVIOUR
//  Reset: state=IDLE; mcand, mplier, acc, cnt, result = 0; stall=busy=done=0.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: stall = start & ~flush (combinational). On start & ~flush: mcand<=operand_a,
//    mplier<=operand_b, acc<=0, cnt<=0, -> RUN. start & flush same cycle: ignored.
//  RUN: stall=1. Each cycle: if mplier[0] acc<=acc+mcand (mod 2^WIDTH); mcand<=mcand<<1
//    (truncated); mplier<=mplier>>1; cnt<=cnt+1. At cnt==WIDTH-1: result<=final acc
//    (incl. this step's add), -> DONE.
//  DONE: done=1, stall=0, busy=1; -> IDLE. start is ignored in DONE (same MUL still in EX).
//  Latency: start seen cycle 0; RUN cycles 1..WIDTH; done at cycle WIDTH+1;
//    stall high cycles 0..WIDTH (WIDTH+1 stall cycles).
//  flush in RUN or DONE: -> IDLE next cycle, done not (further) asserted, result unchanged,
//    stall=0 in the flush cycle.
//  rst asserted mid-operation: same as reset values on next edge; no done pulse.
//  result holds its value until next completed multiply; unaffected by flush/abort.
//  Operands sampled only at the IDLE->RUN edge; later operand changes have no effect.
// CONFIGURATION
//  MUL_EARLY_TERM_EN defined: in RUN, also -> DONE when (mplier>>1)==0 after the current step
//    (remaining multiplier bits zero); result identical. operand_b=0 or 1 -> done at cycle 2.
//  Not defined: fixed latency, done always at cycle WIDTH+1.
// STRUCTURE
//  Shared package cpu_pkg: ALU_OP encodings (ADD/SUB/R_TYPE/MUL_OPCODE), mul state encoding
//    (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
//  One sub-module natural: mul_step (combinational: acc, mcand, mplier -> next acc, mcand, mplier).
//  FSM, counter and output regs stay in mul_sequencer.
// TESTING
//  T1 start, a=3, b=5 (macro off) -> stall cycles 0..32, done pulse cycle 33, result=15.
//  T2 a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> result=32'h0000_0001; a=32'h8000_0000, b=2 -> result=0.
//  T3 start, flush at cycle 10 -> stall low cycle 10, busy low cycle 11, no done, result unchanged.
//  T4 rst at cycle 5 of RUN -> cycle 6: busy=stall=done=0, result=0; new start completes normally.
//  T5 start held through DONE, new start cycle 34 with a=7,b=6 -> single done at 33, next done at 67, result=42.
//  T6 MUL_EARLY_TERM_EN, a=9, b=1 -> done cycle 2, result=9; b=32'h8000_0000 -> done cycle 33.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ALU opcode and multiply-sequencer state encodings
package cpu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_SUB    = 2'b01,
    ALU_R_TYPE = 2'b10,
    MUL_OPCODE = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one combinational shift-add multiply step
module mul_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0] mplier_o
);

  // Sums wrap modulo 2^WIDTH: only the low half of the product is kept.
  assign acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
  assign mcand_o  = mcand_i << 1;
  assign mplier_o = mplier_i >> 1;

endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - iterative shift-add MUL controller for EX; optional MUL_EARLY_TERM_EN
module mul_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mul_state_e       state_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, result_q;
  logic [WIDTH-1:0] mcand_d, mplier_d, acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last_step;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_d),
    .mcand_o  (mcand_d),
    .mplier_o (mplier_d)
  );

`ifdef MUL_EARLY_TERM_EN
  // Once no multiplier bits remain the accumulator cannot change any more.
  assign last_step = (cnt_q == LAST_CNT) || (mplier_d == '0);
`else
  assign last_step = (cnt_q == LAST_CNT);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        MUL_IDLE: begin
          if (start && !flush) begin
            mcand_q  <= operand_a;
            mplier_q <= operand_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          if (flush) begin
            state_q <= MUL_IDLE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_q + 1'b1;
            if (last_step) begin
              result_q <= acc_d;
              state_q  <= MUL_DONE;
            end
          end
        end
        // start is ignored here: the same MUL is still sitting in EX.
        MUL_DONE: state_q <= MUL_IDLE;
        default:  state_q <= MUL_IDLE;
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    unique case (state_q)
      MUL_IDLE: stall = start & ~flush;
      MUL_RUN:  stall = ~flush;
      default:  stall = 1'b0;
    endcase
  end

  assign busy   = (state_q != MUL_IDLE);
  assign done   = (state_q == MUL_DONE) & ~flush;
  assign result = result_q;

endmodule
